// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcode and arbiter state types shared by alu_share_arb
// and its round-robin arbiter, plus the ALU control width.
package alu_pkg;

    localparam int ALU_CTRL_W = 4;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        AND  = 4'd2,
        OR   = 4'd3,
        XOR  = 4'd4,
        SLT  = 4'd5,
        CTZ  = 4'd6,
        CLZ  = 4'd7,
        CPOP = 4'd8
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; search begins one past
// last_grant. Ports: req, last_grant in; one-hot grant and grant_idx out.
module rr_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic             found;
    int               idx;
    logic [IDX_W-1:0] idx_l;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        idx_l     = '0;
        // Walk i = 1..NUM_REQ so last_grant itself is checked last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx   = (int'(last_grant) + i) % NUM_REQ;
            idx_l = IDX_W'(idx);
            if (!found && req[idx_l]) begin
                found        = 1'b1;
                grant[idx_l] = 1'b1;
                grant_idx    = idx_l;
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one combinational ALU between NUM_REQ requesters.
// Ports: req_* (valid/ready, packed a/b/op), resp_* (valid/ready, shared
// result/zero), alu_* (operands out, result/zero in). Optional macro
// ALU_ARB_PERF_EN adds perf_grants (16-bit saturating per-requester grant
// counters) and perf_clr (synchronous clear).
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b,
    input  logic [NUM_REQ*4-1:0]        req_op,
    output logic [NUM_REQ-1:0]          resp_valid,
    input  logic [NUM_REQ-1:0]          resp_ready,
    output logic [DATA_W-1:0]           resp_result,
    output logic                        resp_zero,
    output logic [DATA_W-1:0]           alu_a,
    output logic [DATA_W-1:0]           alu_b,
    output logic [ALU_CTRL_W-1:0]       alu_ctrl,
    input  logic [DATA_W-1:0]           alu_result,
    input  logic                        alu_zero
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [NUM_REQ*16-1:0]       perf_grants,
    input  logic                        perf_clr
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t            state_q, state_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [IDX_W-1:0]      last_q, last_d;
    logic [DATA_W-1:0]     a_q, a_d;
    logic [DATA_W-1:0]     b_q, b_d;
    logic [ALU_CTRL_W-1:0] op_q, op_d;
    logic [DATA_W-1:0]     res_q, res_d;
    logic                  zero_q, zero_d;

    logic [NUM_REQ-1:0]    grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  drain;
    logic                  accept;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_q),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    always_comb begin
        drain   = (state_q == RESP) && resp_ready[owner_q];
        // A slot opens in IDLE or in the same cycle the owner drains.
        accept  = (|req_valid) && ((state_q == IDLE) || drain);
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        zero_d  = zero_q;
        if (accept) begin
            owner_d = grant_idx;
            last_d  = grant_idx;
            a_d     = req_a[int'(grant_idx)*DATA_W +: DATA_W];
            b_d     = req_b[int'(grant_idx)*DATA_W +: DATA_W];
            op_d    = req_op[int'(grant_idx)*ALU_CTRL_W +: ALU_CTRL_W];
        end
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = EXEC;
            end
            EXEC: begin
                res_d   = alu_result;
                zero_d  = alu_zero;
                state_d = RESP;
            end
            RESP: begin
                if (accept)     state_d = EXEC;
                else if (drain) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

    // resp_valid decodes only registered state: no path from req_*.
    always_comb begin
        resp_valid = '0;
        if (state_q == RESP) resp_valid[owner_q] = 1'b1;
    end

    assign req_ready   = accept ? grant : '0;
    assign resp_result = res_q;
    assign resp_zero   = zero_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_ctrl    = op_q;

`ifdef ALU_ARB_PERF_EN
    logic [NUM_REQ*16-1:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (perf_clr) begin
                perf_d[i*16 +: 16] = '0;
            end else if (accept && grant_idx == IDX_W'(i)
                         && perf_q[i*16 +: 16] != 16'hFFFF) begin
                perf_d[i*16 +: 16] = perf_q[i*16 +: 16] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign perf_grants = perf_q;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: randomized + directed bench for alu_share_arb with a
// transaction-level reference model and a behavioural ALU.
module tb_alu_share_arb;
    import alu_pkg::*;

    localparam int N = 2;
    localparam int W = 32;

    logic           clk, rst_n;
    logic [N-1:0]   req_valid, req_ready, resp_valid, resp_ready;
    logic [N*W-1:0] req_a, req_b;
    logic [N*4-1:0] req_op;
    logic [W-1:0]   resp_result, alu_a, alu_b, alu_result;
    logic           resp_zero, alu_zero;
    logic [3:0]     alu_ctrl;
`ifdef ALU_ARB_PERF_EN
    logic [N*16-1:0] perf_grants;
    logic            perf_clr;
`endif

    alu_share_arb #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero)
`ifdef ALU_ARB_PERF_EN
        ,
        .perf_grants (perf_grants),
        .perf_clr    (perf_clr)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural ALU; Zero doubles as the branch-taken flag for SLT.
    function automatic logic [W:0] alu_fn(logic [3:0] op, logic [W-1:0] a,
                                          logic [W-1:0] b);
        logic [W-1:0] r;
        int           n;
        r = '0;
        n = 0;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ($signed(a) < $signed(b)) ? 1 : 0;
            4'd6: begin
                n = W;
                for (int i = W - 1; i >= 0; i--) if (a[i]) n = i;
                r = W'(n);
            end
            4'd7: begin
                n = W;
                for (int i = 0; i < W; i++) if (a[i]) n = W - 1 - i;
                r = W'(n);
            end
            4'd8: begin
                for (int i = 0; i < W; i++) if (a[i]) n++;
                r = W'(n);
            end
            default: r = '0;
        endcase
        return {(op == 4'd5) ? r[0] : (r == '0), r};
    endfunction

    always_comb {alu_zero, alu_result} = alu_fn(alu_ctrl, alu_a, alu_b);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: one outstanding transaction, visible 2 cycles
    // after acceptance, plus a round-robin pointer kept as an integer.
    int           cyc;
    bit           has_op;
    int           m_owner, m_vis, m_last;
    logic [W-1:0] m_res, m_a, m_b;
    logic         m_zero;
    logic [3:0]   m_op;
    int           m_cnt [N];
    logic [W-1:0] sa [N];
    logic [W-1:0] sb [N];
    logic [3:0]   so [N];
    logic [N-1:0] obs_rdy;

    task automatic model_reset();
        has_op = 0;
        m_last = N - 1;
        m_res  = '0;
        m_zero = 1'b0;
        m_a    = '0;
        m_b    = '0;
        m_op   = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    task automatic run_cycle(input logic [N-1:0] v, input logic [N-1:0] rr);
        logic [N-1:0] er, ev;
        logic [W:0]   f;
        bit           vis, can;
        int           g, j;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = sa[i];
            req_b[i*W +: W] = sb[i];
            req_op[i*4 +: 4] = so[i];
        end
        req_valid  = v;
        resp_ready = rr;
        #1;
        obs_rdy = req_ready;
        vis = has_op && (cyc >= m_vis);
        ev  = '0;
        if (vis) ev[m_owner] = 1'b1;
        can = !has_op || (vis && rr[m_owner]);
        g = -1;
        if (can) begin
            for (int k = 1; k <= N; k++) begin
                j = (m_last + k) % N;
                if (g < 0 && v[j]) g = j;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", req_ready, er);
        chk("resp_valid", resp_valid, ev);
        if (vis) begin
            chk("resp_result", resp_result, m_res);
            chk("resp_zero", resp_zero, m_zero);
        end
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_ctrl", alu_ctrl, m_op);
        if (can) has_op = 0;
        if (g >= 0) begin
            has_op  = 1;
            m_owner = g;
            m_vis   = cyc + 2;
            f       = alu_fn(so[g], sa[g], sb[g]);
            m_res   = f[W-1:0];
            m_zero  = f[W];
            m_a     = sa[g];
            m_b     = sb[g];
            m_op    = so[g];
            m_last  = g;
            if (m_cnt[g] < 65535) m_cnt[g]++;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain_all();
        repeat (3) run_cycle('0, '1);
    endtask

    int k;

    initial begin
        clk        = 1'b0;
        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = '0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
`ifdef ALU_ARB_PERF_EN
        perf_clr   = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            sa[i] = '0;
            sb[i] = '0;
            so[i] = '0;
        end
        model_reset();
        cyc = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_result", resp_result, 0);
        chk("rst_zero", resp_zero, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_ctrl", alu_ctrl, 0);

        // Single ADD from requester 0.
        sa[0] = 32'd5; sb[0] = 32'd7; so[0] = ADD;
        run_cycle(2'b01, 2'b00);
        run_cycle(2'b00, 2'b00);
        #1;
        chk("single_valid", resp_valid, 2'b01);
        chk("single_result", resp_result, 32'd12);
        chk("single_zero", resp_zero, 0);
        run_cycle(2'b00, 2'b01);

        // Contention: pointer sits at 0, so 1,0,1,0... every 2 cycles.
        sa[0] = 32'd100; sb[0] = 32'd1; so[0] = SUB;
        sa[1] = 32'h0F; sb[1] = 32'hF0; so[1] = OR;
        k = 0;
        for (int c = 0; c < 20; c++) begin
            run_cycle(2'b11, 2'b11);
            if (obs_rdy != '0) begin
                chk("rr_order", obs_rdy, (k % 2 == 0) ? 2'b10 : 2'b01);
                k++;
            end
        end
        chk("rr_count", k, 10);
        drain_all();

        // Backpressure on requester 1; resp_ready[0] is a non-owner.
        sa[1] = 32'hF0F0_0000; sb[1] = 32'd0; so[1] = CPOP;
        run_cycle(2'b10, 2'b00);
        run_cycle(2'b11, 2'b00);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_result", resp_result, 32'd8);
            chk("bp_ready", req_ready, 2'b00);
            run_cycle(2'b11, 2'b01);
        end
        run_cycle(2'b11, 2'b10);
        drain_all();

        // Branch flags.
        sa[0] = 32'h1234; sb[0] = 32'h1234; so[0] = SUB;
        run_cycle(2'b01, 2'b00);
        run_cycle(2'b00, 2'b00);
        #1;
        chk("sub_zero", resp_zero, 1);
        run_cycle(2'b00, 2'b01);
        sa[1] = 32'hFFFF_FFFF; sb[1] = 32'd1; so[1] = SLT;
        run_cycle(2'b10, 2'b00);
        run_cycle(2'b00, 2'b00);
        #1;
        chk("slt_result", resp_result, 32'd1);
        chk("slt_zero", resp_zero, 1);
        run_cycle(2'b00, 2'b10);

        // Reset in the middle of EXEC.
        sa[0] = 32'hDEAD; sb[0] = 32'hBEEF; so[0] = XOR;
        run_cycle(2'b01, 2'b00);
        req_valid = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", resp_valid, 0);
        chk("mid_rst_result", resp_result, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_b", alu_b, 0);
        chk("mid_rst_ready", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        sa[1] = 32'h8; sb[1] = 32'd0; so[1] = CTZ;
        run_cycle(2'b10, 2'b00);
        run_cycle(2'b00, 2'b00);
        run_cycle(2'b00, 2'b10);
        run_cycle(2'b11, 2'b11);
        chk("ptr_after_rst", obs_rdy, 2'b01);
        drain_all();

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                sa[i] = $urandom;
                sb[i] = ($urandom_range(0, 3) == 0) ? sa[i] : $urandom;
                so[i] = 4'($urandom_range(0, 15));
            end
            run_cycle(N'($urandom), N'($urandom));
        end
        drain_all();

`ifdef ALU_ARB_PERF_EN
        so[0] = ADD;
        for (int c = 0; c < 140000; c++) run_cycle(2'b01, 2'b01);
        drain_all();
        chk("perf0_sat", perf_grants[15:0], 16'hFFFF);
        chk("perf0_model", perf_grants[15:0], m_cnt[0]);
        chk("perf1_model", perf_grants[31:16], m_cnt[1]);
        perf_clr = 1'b1;
        run_cycle(2'b00, 2'b11);
        perf_clr = 1'b0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        #1;
        chk("perf_clr", perf_grants, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Round-robin arbiter and sequencer that shares the single execute-stage ALU between NUM_REQ requesters, for example the main pipeline and a debug/CSR helper. It captures one requester's operands and opcode, drives the ALU from registered operands, and holds the registered result and Zero flag until the owning requester accepts it. The ALU stays a separate combinational instance; this block only drives its inputs and samples its outputs.

## Interface
- NUM_REQ, default 2: number of requesters; legal range 2..8.
- DATA_W, default 32: operand and result width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*DATA_W  packed operand A; requester i occupies slice [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  packed operand B, same packing as req_a.
- req_op  in  NUM_REQ*4  packed 4-bit ALU control per requester.
- resp_valid  out  NUM_REQ  result valid; one-hot, asserted only for the owning requester.
- resp_ready  in  NUM_REQ  per-requester result accept.
- resp_result  out  DATA_W  registered result, shared by all requesters.
- resp_zero  out  1  registered Zero flag.
- alu_a / alu_b  out  DATA_W  ALU operands, driven from the operand register.
- alu_ctrl  out  4  ALU control.
- alu_result  in  DATA_W  combinational ALU result.
- alu_zero  in  1  combinational ALU Zero flag.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE: when any req_valid is high, the round-robin grant selects requester g.
  - req_ready[g]=1; the request is accepted on that same edge.
  - On acceptance: opcode register and operand registers load from slice g, owner register loads g, next state is EXEC.
- EXEC: alu_a, alu_b and alu_ctrl come from the registers.
  - At end of cycle, alu_result and alu_zero are captured into resp_result and resp_zero.
  - Next state is RESP.
- RESP: resp_valid[owner]=1. resp_result and resp_zero stay stable until resp_ready[owner] is high.
  - On drain, if any req_valid is high, a new grant is issued in the same cycle, the new request is accepted, and the next state is EXEC (back-to-back operation).
  - On drain with no request pending, the next state is IDLE.
  - While not draining, req_ready is 0.
- Round-robin pointer:
  - last_grant resets to NUM_REQ-1, so requester 0 wins first.
  - Search starts at last_grant+1, modulo NUM_REQ.
  - last_grant updates only on acceptance.
- Opcodes are not filtered; opcodes 9..15 pass through unchanged, and the ALU returns 0 for them.
- alu_a, alu_b and alu_ctrl are held in every state. They change only on acceptance.
- A requester may drop req_valid before it is granted; there is no penalty.
- req_ready depends combinationally on req_valid. There is no combinational path from req_* to resp_*.

## Timing
- Accept in cycle T, EXEC in T+1, resp_valid high in T+2. Latency is 2 cycles.
- Best-case throughput is one operation per 2 cycles, reached when every response drains in the cycle it appears.
- Reset values:
  - req_ready=0, resp_valid=0, resp_result=0, resp_zero=0.
  - alu_a=0, alu_b=0, alu_ctrl=0.
  - last_grant=NUM_REQ-1, owner=0.
- Reset asserted mid-EXEC or mid-RESP: the in-flight operation is discarded with no response, and the FSM returns to IDLE immediately (asynchronous reset).
- resp_ready on a non-owner index is ignored.
- Simultaneous drain and new request from the same requester: legal; that requester is re-granted only if no other requester is valid.

## Configuration
- ALU_ARB_PERF_EN defined:
  - Adds output perf_grants of width NUM_REQ*16: one saturating 16-bit grant counter per requester.
  - Each counter increments on that requester's acceptance and resets to 0.
  - Adds input perf_clr, which synchronously clears all counters; clear takes priority over increment.
- ALU_ARB_PERF_EN undefined: perf_grants, perf_clr and the counters do not exist. All other behaviour is identical.

## Structure
- alu_pkg holds:
  - The ALU opcode enum alu_op_t: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, CTZ=6, CLZ=7, CPOP=8.
  - The arbiter state enum arb_state_t: IDLE, EXEC, RESP.
  - Constant ALU_CTRL_W=4.
- Sub-module rr_arbiter, parameterised by NUM_REQ: inputs req and last_grant; output one-hot grant and encoded grant index. Combinational.

## Test plan
- Reset: mid-EXEC, pulse rst_n low -> all outputs at their reset values. First request after release is from requester 1 only -> requester 1 is served, then requester 0 is preferred (pointer reset checked).
- Single op: requester 0 sends ADD a=5, b=7 at T -> resp_valid[0]=1 at T+2, resp_result=12, resp_zero=0.
- Contention: both requesters valid continuously, resp_ready always 1 -> grants alternate 0,1,0,1 with no idle cycles between operations.
- Backpressure: requester 1 sends CPOP a=0xF0F0_0000 and holds resp_ready[1]=0 for 3 cycles -> resp_result=8 stays stable and req_ready stays 0 throughout.
- Branch flag: SUB a=b=0x1234 -> resp_zero=1. SLT a=0xFFFF_FFFF, b=1 -> resp_result=1, resp_zero=1.
- With ALU_ARB_PERF_EN: 70000 grants to requester 0 -> counter saturates at 0xFFFF; perf_clr -> counter reads 0.
